// File: rtl/dijkstra_pkg.sv
// Shared types and sizing for the shortest-path relaxation stage.
package dijkstra_pkg;

  localparam int NODES   = 64;
  localparam int NODE_W  = $clog2(NODES);
  localparam int MAX_DEG = 4;
  localparam int SLOT_W  = $clog2(MAX_DEG);
  localparam int DIST_W  = 16;
  localparam int WGT_W   = 8;
  localparam int EADDR_W = NODE_W + SLOT_W;
  localparam int EDGE_W  = 1 + NODE_W + WGT_W;

  localparam logic [DIST_W-1:0] INF = '1;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    SEED,
    POP,
    WAIT_POP,
    CHECK,
    FETCH,
    WAIT_EDGE,
    RELAX,
    GAP,
    DONE
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [NODE_W-1:0] dst;
    logic [WGT_W-1:0]  weight;
  } edge_t;

endpackage

// File: rtl/dist_table.sv
// Distance register file: one write port, one combinational read for the FSM,
// one registered readout port (same-cycle write returns the old value).
module dist_table
  import dijkstra_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              we,
  input  logic [NODE_W-1:0] waddr,
  input  logic [DIST_W-1:0] wdata,
  input  logic [NODE_W-1:0] raddr,
  output logic [DIST_W-1:0] rdata,
  input  logic [NODE_W-1:0] rd_node,
  output logic [DIST_W-1:0] rd_dist
);

  logic [DIST_W-1:0] mem_q [NODES];
  logic [DIST_W-1:0] rd_dist_q, rd_dist_d;

  always_comb begin
    rd_dist_d = mem_q[rd_node];
  end

  assign rdata   = mem_q[raddr];
  assign rd_dist = rd_dist_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_dist_q <= '0;
    end else begin
      rd_dist_q <= rd_dist_d;
    end
  end

  // Table contents are not reset; every run rewrites all entries in INIT.
  always_ff @(posedge clk_in) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/dijkstra_relax.sv
// SSSP control: seeds the priority queue, pops minimum nodes, relaxes their edges.
// Registered strobes; stalls in RELAX while pq_full, waits in WAIT_POP for pq_valid.
module dijkstra_relax
  import dijkstra_pkg::*;
(
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               start,
  input  logic [NODE_W-1:0]  src_node,
  output logic               pq_deq,
  input  logic [NODE_W-1:0]  pq_data,
  input  logic [DIST_W-1:0]  pq_tag,
  input  logic               pq_valid,
  input  logic               pq_empty,
  input  logic               pq_full,
  output logic               pq_enq,
  output logic [NODE_W-1:0]  pq_enq_data,
  output logic [DIST_W-1:0]  pq_enq_tag,
  output logic [EADDR_W-1:0] edge_addr,
  input  logic [EDGE_W-1:0]  edge_rdata,
  input  logic [NODE_W-1:0]  rd_node,
  output logic [DIST_W-1:0]  rd_dist,
  output logic               busy,
  output logic               done
);

  localparam logic [SLOT_W-1:0] K_LAST = SLOT_W'(MAX_DEG - 1);
  localparam logic [NODE_W-1:0] N_LAST = NODE_W'(NODES - 1);

  state_t             state_q, state_d;
  logic [NODE_W-1:0]  cnt_q, cnt_d;
  logic [NODE_W-1:0]  u_q, u_d;
  logic [DIST_W-1:0]  d_q, d_d;
  logic [SLOT_W-1:0]  k_q, k_d;
  logic               hold_q, hold_d;
  logic               pend_q, pend_d;
  logic               pq_deq_q, pq_deq_d;
  logic               pq_enq_q, pq_enq_d;
  logic [NODE_W-1:0]  pq_enq_data_q, pq_enq_data_d;
  logic [DIST_W-1:0]  pq_enq_tag_q, pq_enq_tag_d;
  logic [EADDR_W-1:0] edge_addr_q, edge_addr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  edge_t              edge_in;
  logic               tbl_we;
  logic [NODE_W-1:0]  tbl_waddr, tbl_raddr;
  logic [DIST_W-1:0]  tbl_wdata, tbl_rdata;
  logic [DIST_W:0]    nd;
  logic               improve;

  assign edge_in   = edge_t'(edge_rdata);
  assign tbl_raddr = (state_q == RELAX) ? edge_in.dst : u_q;

  dist_table u_dist_table (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .we      (tbl_we),
    .waddr   (tbl_waddr),
    .wdata   (tbl_wdata),
    .raddr   (tbl_raddr),
    .rdata   (tbl_rdata),
    .rd_node (rd_node),
    .rd_dist (rd_dist)
  );

  // One extra bit so a sum past INF cannot wrap into a small distance.
  always_comb begin
    nd      = {1'b0, d_q} + {{(DIST_W + 1 - WGT_W){1'b0}}, edge_in.weight};
    improve = edge_in.valid && (nd < {1'b0, tbl_rdata}) && (nd < {1'b0, INF});
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    u_d           = u_q;
    d_d           = d_q;
    k_d           = k_q;
    hold_d        = hold_q;
    pend_d        = pend_q;
    pq_deq_d      = 1'b0;
    pq_enq_d      = 1'b0;
    pq_enq_data_d = pq_enq_data_q;
    pq_enq_tag_d  = pq_enq_tag_q;
    edge_addr_d   = edge_addr_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    tbl_we        = 1'b0;
    tbl_waddr     = cnt_q;
    tbl_wdata     = INF;

    case (state_q)
      IDLE: begin
        if (start) begin
          u_d     = src_node;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = INIT;
        end
      end
      INIT: begin
        tbl_we = 1'b1;
        cnt_d  = cnt_q + NODE_W'(1);
        if (cnt_q == N_LAST) state_d = SEED;
      end
      SEED: begin
        tbl_we        = 1'b1;
        tbl_waddr     = u_q;
        tbl_wdata     = '0;
        pq_enq_d      = 1'b1;
        pq_enq_data_d = u_q;
        pq_enq_tag_d  = '0;
        // Last slot index makes GAP fall through to POP.
        k_d           = K_LAST;
        hold_d        = 1'b0;
        state_d       = GAP;
      end
      GAP: begin
        if (!hold_q) begin
          hold_d = 1'b1;
        end else begin
          hold_d = 1'b0;
          if (k_q == K_LAST) begin
            state_d = POP;
          end else begin
            k_d     = k_q + SLOT_W'(1);
            state_d = FETCH;
          end
        end
      end
      POP: begin
        if (pq_empty) begin
          state_d = DONE;
        end else begin
          pq_deq_d = 1'b1;
          state_d  = WAIT_POP;
        end
      end
      WAIT_POP: begin
        if (pq_valid) begin
          u_d     = pq_data;
          d_d     = pq_tag;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (d_q > tbl_rdata) begin
          state_d = POP;
        end else begin
          k_d     = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        edge_addr_d = {u_q, k_q};
        hold_d      = 1'b0;
        state_d     = WAIT_EDGE;
      end
      WAIT_EDGE: begin
        if (!hold_q) begin
          hold_d = 1'b1;
        end else begin
          hold_d  = 1'b0;
          state_d = RELAX;
        end
      end
      RELAX: begin
        // pend_q: table already updated, enqueue held back by a full queue.
        if (pend_q) begin
          if (!pq_full) begin
            pq_enq_d = 1'b1;
            pend_d   = 1'b0;
            hold_d   = 1'b0;
            state_d  = GAP;
          end
        end else if (!edge_in.valid) begin
          state_d = POP;
        end else if (improve) begin
          tbl_we        = 1'b1;
          tbl_waddr     = edge_in.dst;
          tbl_wdata     = nd[DIST_W-1:0];
          pq_enq_data_d = edge_in.dst;
          pq_enq_tag_d  = nd[DIST_W-1:0];
          if (pq_full) begin
            pend_d = 1'b1;
          end else begin
            pq_enq_d = 1'b1;
            hold_d   = 1'b0;
            state_d  = GAP;
          end
        end else if (k_q == K_LAST) begin
          state_d = POP;
        end else begin
          k_d     = k_q + SLOT_W'(1);
          state_d = FETCH;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      u_q           <= '0;
      d_q           <= '0;
      k_q           <= '0;
      hold_q        <= 1'b0;
      pend_q        <= 1'b0;
      pq_deq_q      <= 1'b0;
      pq_enq_q      <= 1'b0;
      pq_enq_data_q <= '0;
      pq_enq_tag_q  <= '0;
      edge_addr_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      u_q           <= u_d;
      d_q           <= d_d;
      k_q           <= k_d;
      hold_q        <= hold_d;
      pend_q        <= pend_d;
      pq_deq_q      <= pq_deq_d;
      pq_enq_q      <= pq_enq_d;
      pq_enq_data_q <= pq_enq_data_d;
      pq_enq_tag_q  <= pq_enq_tag_d;
      edge_addr_q   <= edge_addr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign pq_deq      = pq_deq_q;
  assign pq_enq      = pq_enq_q;
  assign pq_enq_data = pq_enq_data_q;
  assign pq_enq_tag  = pq_enq_tag_q;
  assign edge_addr   = edge_addr_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_dijkstra_relax.sv
// Directed bench for dijkstra_relax with a behavioural min-queue and 2-cycle edge memory.
module tb_dijkstra_relax;
  import dijkstra_pkg::*;

  logic               clk_in;
  logic               rst_in;
  logic               start;
  logic [NODE_W-1:0]  src_node;
  logic               pq_deq;
  logic [NODE_W-1:0]  pq_data;
  logic [DIST_W-1:0]  pq_tag;
  logic               pq_valid;
  logic               pq_empty;
  logic               pq_full;
  logic               pq_enq;
  logic [NODE_W-1:0]  pq_enq_data;
  logic [DIST_W-1:0]  pq_enq_tag;
  logic [EADDR_W-1:0] edge_addr;
  logic [EDGE_W-1:0]  edge_rdata;
  logic [NODE_W-1:0]  rd_node;
  logic [DIST_W-1:0]  rd_dist;
  logic               busy;
  logic               done;

  int total = 0;
  int bad   = 0;

  dijkstra_relax dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .start       (start),
    .src_node    (src_node),
    .pq_deq      (pq_deq),
    .pq_data     (pq_data),
    .pq_tag      (pq_tag),
    .pq_valid    (pq_valid),
    .pq_empty    (pq_empty),
    .pq_full     (pq_full),
    .pq_enq      (pq_enq),
    .pq_enq_data (pq_enq_data),
    .pq_enq_tag  (pq_enq_tag),
    .edge_addr   (edge_addr),
    .edge_rdata  (edge_rdata),
    .rd_node     (rd_node),
    .rd_dist     (rd_dist),
    .busy        (busy),
    .done        (done)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Priority queue model: pop returns the minimum tag (earliest on ties) one cycle later.
  logic [NODE_W-1:0] qn [64];
  logic [DIST_W-1:0] qt [64];
  int                qc = 0;
  logic              pl_req;
  logic [NODE_W-1:0] pl_node;
  logic [DIST_W-1:0] pl_tag;

  assign pq_empty = (qc == 0);

  always @(posedge clk_in) begin
    int n;
    int best;
    n = qc;
    pq_valid <= 1'b0;
    if (rst_in) begin
      n = 0;
    end else begin
      if (pl_req && n < 64) begin
        qn[n] = pl_node; qt[n] = pl_tag; n++;
      end
      if (pq_enq && n < 64) begin
        qn[n] = pq_enq_data; qt[n] = pq_enq_tag; n++;
      end
      if (pq_deq && n > 0) begin
        best = 0;
        for (int i = 1; i < n; i++) if (qt[i] < qt[best]) best = i;
        pq_data  <= qn[best];
        pq_tag   <= qt[best];
        pq_valid <= 1'b1;
        for (int i = best; i < n - 1; i++) begin
          qn[i] = qn[i+1]; qt[i] = qt[i+1];
        end
        n--;
      end
    end
    qc <= n;
  end

  logic [EDGE_W-1:0] emem [256];
  logic [EDGE_W-1:0] e_s1;
  always @(posedge clk_in) begin
    e_s1       <= emem[edge_addr];
    edge_rdata <= e_s1;
  end

  // Monitor: enqueue log, pop/fetch counts, strobe overlap and enqueue spacing.
  int                cyc      = 0;
  int                last_enq = -100;
  int                viol     = 0;
  int                enq_n    = 0;
  int                deq_n    = 0;
  int                fetch_n  = 0;
  logic [NODE_W-1:0] enq_node [256];
  logic [DIST_W-1:0] enq_tag  [256];

  always @(negedge clk_in) begin
    cyc++;
    if (pq_enq) begin
      if (pq_deq) viol++;
      if (cyc - last_enq < 3) viol++;
      if (enq_n < 256) begin
        enq_node[enq_n] = pq_enq_data;
        enq_tag[enq_n]  = pq_enq_tag;
      end
      enq_n++;
      last_enq = cyc;
    end
    if (pq_deq) deq_n++;
    if (dut.state_q == FETCH) fetch_n++;
  end

  task automatic clear_edges();
    for (int i = 0; i < 256; i++) emem[i] = '0;
  endtask

  task automatic set_edge(input int node, input int slot, input int dst, input int w);
    emem[node * MAX_DEG + slot] = {1'b1, NODE_W'(dst), WGT_W'(w)};
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_in);
    end
  endtask

  task automatic run_graph(input int src, output bit ok);
    @(negedge clk_in);
    src_node = NODE_W'(src);
    start    = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    wait_done(ok);
  endtask

  task automatic read_dist(input int n, output logic [DIST_W-1:0] v);
    rd_node = NODE_W'(n);
    @(negedge clk_in);
    v = rd_dist;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    total++;
    if ({pq_deq, pq_enq, busy, done} !== 4'b0000) begin
      bad++; $display("FAIL reset_strobes: got %b want 0000", {pq_deq, pq_enq, busy, done});
    end
    total++;
    if (pq_enq_data !== '0 || pq_enq_tag !== '0) begin
      bad++; $display("FAIL reset_enq_bus: got %0h/%0h want 0/0", pq_enq_data, pq_enq_tag);
    end
    total++;
    if (edge_addr !== '0) begin
      bad++; $display("FAIL reset_edge_addr: got %0h want 0", edge_addr);
    end
    total++;
    if (rd_dist !== '0) begin
      bad++; $display("FAIL reset_rd_dist: got %0h want 0", rd_dist);
    end
    total++;
    if (dut.state_q !== IDLE) begin
      bad++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, IDLE);
    end
    rst_in = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic test_mid_init();
    int e0;
    e0 = enq_n;
    src_node = NODE_W'(3);
    start    = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    repeat (9) @(negedge clk_in);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL midinit_busy_before: got %b want 1", busy);
    end
    rst_in = 1'b1;
    @(negedge clk_in);
    total++;
    if ({pq_deq, pq_enq, busy, done} !== 4'b0000 || edge_addr !== '0 || pq_enq_tag !== '0) begin
      bad++; $display("FAIL midinit_outputs: got %b %0h %0h want 0000 0 0",
                      {pq_deq, pq_enq, busy, done}, edge_addr, pq_enq_tag);
    end
    total++;
    if (dut.state_q !== IDLE) begin
      bad++; $display("FAIL midinit_state: got %0d want %0d", dut.state_q, IDLE);
    end
    rst_in = 1'b0;
    repeat (3) @(negedge clk_in);
    total++;
    if (enq_n != e0 || busy !== 1'b0) begin
      bad++; $display("FAIL midinit_no_enq: got enq=%0d busy=%b want enq=0 busy=0", enq_n - e0, busy);
    end
  endtask

  task automatic test_isolated();
    bit                ok;
    int                e0, d0;
    logic [DIST_W-1:0] v;
    clear_edges();
    e0 = enq_n; d0 = deq_n;
    run_graph(0, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL iso_done: got timeout want done pulse");
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL iso_busy: got %b want 0 with done", busy);
    end
    @(negedge clk_in);
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL iso_done_width: got %b want 0 one cycle later", done);
    end
    total++;
    if (enq_n - e0 != 1 || enq_node[e0] !== 6'd0 || enq_tag[e0] !== 16'd0) begin
      bad++; $display("FAIL iso_enq: got n=%0d {%0d,%0h} want n=1 {0,0}", enq_n - e0, enq_node[e0], enq_tag[e0]);
    end
    total++;
    if (deq_n - d0 != 1) begin
      bad++; $display("FAIL iso_deq: got %0d want 1", deq_n - d0);
    end
    read_dist(0, v);
    total++;
    if (v !== 16'h0000) begin
      bad++; $display("FAIL iso_dist0: got %0h want 0", v);
    end
    read_dist(1, v);
    total++;
    if (v !== 16'hFFFF) begin
      bad++; $display("FAIL iso_dist1: got %0h want ffff", v);
    end
    read_dist(63, v);
    total++;
    if (v !== 16'hFFFF) begin
      bad++; $display("FAIL iso_dist63: got %0h want ffff", v);
    end
  endtask

  task automatic test_chain();
    bit                ok;
    int                e0;
    logic [DIST_W-1:0] v;
    int                en [3] = '{0, 1, 2};
    int                et [3] = '{0, 5, 8};
    clear_edges();
    set_edge(0, 0, 1, 5);
    set_edge(1, 0, 2, 3);
    e0 = enq_n;
    run_graph(0, ok);
    total++;
    if (!ok || enq_n - e0 != 3) begin
      bad++; $display("FAIL chain_enq_count: got ok=%b n=%0d want ok=1 n=3", ok, enq_n - e0);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (enq_node[e0+i] !== NODE_W'(en[i]) || enq_tag[e0+i] !== DIST_W'(et[i])) begin
        bad++; $display("FAIL chain_enq%0d: got {%0d,%0d} want {%0d,%0d}", i, enq_node[e0+i], enq_tag[e0+i], en[i], et[i]);
      end
    end
    read_dist(1, v);
    total++;
    if (v !== 16'd5) begin
      bad++; $display("FAIL chain_dist1: got %0d want 5", v);
    end
    read_dist(2, v);
    total++;
    if (v !== 16'd8) begin
      bad++; $display("FAIL chain_dist2: got %0d want 8", v);
    end
  endtask

  task automatic test_diamond();
    bit                ok;
    int                e0, d0, f0;
    logic [DIST_W-1:0] v;
    int                en [4] = '{0, 1, 2, 1};
    int                et [4] = '{0, 10, 1, 3};
    clear_edges();
    set_edge(0, 0, 1, 10);
    set_edge(0, 1, 2, 1);
    set_edge(2, 0, 1, 2);
    e0 = enq_n; d0 = deq_n; f0 = fetch_n;
    run_graph(0, ok);
    total++;
    if (!ok || enq_n - e0 != 4 || deq_n - d0 != 4) begin
      bad++; $display("FAIL dia_counts: got ok=%b enq=%0d deq=%0d want 1 4 4", ok, enq_n - e0, deq_n - d0);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (enq_node[e0+i] !== NODE_W'(en[i]) || enq_tag[e0+i] !== DIST_W'(et[i])) begin
        bad++; $display("FAIL dia_enq%0d: got {%0d,%0d} want {%0d,%0d}", i, enq_node[e0+i], enq_tag[e0+i], en[i], et[i]);
      end
    end
    total++;
    if (fetch_n - f0 != 6) begin
      bad++; $display("FAIL dia_stale_fetch: got %0d fetches want 6", fetch_n - f0);
    end
    read_dist(1, v);
    total++;
    if (v !== 16'd3) begin
      bad++; $display("FAIL dia_dist1: got %0d want 3", v);
    end
    read_dist(2, v);
    total++;
    if (v !== 16'd1) begin
      bad++; $display("FAIL dia_dist2: got %0d want 1", v);
    end
  endtask

  task automatic test_saturate();
    bit                ok;
    int                e0, d0;
    logic [DIST_W-1:0] v;
    clear_edges();
    set_edge(5, 0, 6, 8'hFF);
    set_edge(5, 1, 7, 8'hEF);
    set_edge(5, 2, 8, 8'hEE);
    @(negedge clk_in);
    pl_node = NODE_W'(5);
    pl_tag  = 16'hFF10;
    pl_req  = 1'b1;
    @(negedge clk_in);
    pl_req = 1'b0;
    e0 = enq_n; d0 = deq_n;
    run_graph(0, ok);
    total++;
    if (!ok || enq_n - e0 != 2 || deq_n - d0 != 3) begin
      bad++; $display("FAIL sat_counts: got ok=%b enq=%0d deq=%0d want 1 2 3", ok, enq_n - e0, deq_n - d0);
    end
    total++;
    if (enq_node[e0+1] !== 6'd8 || enq_tag[e0+1] !== 16'hFFFE) begin
      bad++; $display("FAIL sat_enq: got {%0d,%0h} want {8,fffe}", enq_node[e0+1], enq_tag[e0+1]);
    end
    read_dist(6, v);
    total++;
    if (v !== 16'hFFFF) begin
      bad++; $display("FAIL sat_dist6: got %0h want ffff", v);
    end
    read_dist(7, v);
    total++;
    if (v !== 16'hFFFF) begin
      bad++; $display("FAIL sat_dist7: got %0h want ffff", v);
    end
    read_dist(8, v);
    total++;
    if (v !== 16'hFFFE) begin
      bad++; $display("FAIL sat_dist8: got %0h want fffe", v);
    end
  endtask

  task automatic test_full();
    bit                ok;
    int                e0, stall_enq;
    logic [DIST_W-1:0] v;
    clear_edges();
    set_edge(0, 0, 1, 5);
    set_edge(1, 0, 2, 3);
    e0 = enq_n;
    @(negedge clk_in);
    src_node = '0;
    start    = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (pq_deq) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_in);
    end
    total++;
    if (!ok) begin
      bad++; $display("FAIL full_first_pop: got timeout want pq_deq");
    end
    pq_full   = 1'b1;
    stall_enq = 0;
    v         = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (pq_enq) stall_enq++;
      if (i == 15) rd_node = NODE_W'(1);
      if (i == 16) v = rd_dist;
    end
    total++;
    if (stall_enq != 0) begin
      bad++; $display("FAIL full_stall_enq: got %0d enqueues want 0", stall_enq);
    end
    total++;
    if (dut.state_q !== RELAX) begin
      bad++; $display("FAIL full_stall_state: got %0d want %0d", dut.state_q, RELAX);
    end
    total++;
    if (v !== 16'd5) begin
      bad++; $display("FAIL full_dist_written: got %0d want 5", v);
    end
    pq_full = 1'b0;
    @(negedge clk_in);
    total++;
    if (pq_enq !== 1'b1 || pq_enq_data !== 6'd1 || pq_enq_tag !== 16'd5) begin
      bad++; $display("FAIL full_release: got %b {%0d,%0d} want 1 {1,5}", pq_enq, pq_enq_data, pq_enq_tag);
    end
    wait_done(ok);
    total++;
    if (!ok || enq_n - e0 != 3) begin
      bad++; $display("FAIL full_run: got ok=%b enq=%0d want 1 3", ok, enq_n - e0);
    end
    read_dist(2, v);
    total++;
    if (v !== 16'd8) begin
      bad++; $display("FAIL full_dist2: got %0d want 8", v);
    end
  endtask

  initial begin
    rst_in   = 1'b1;
    start    = 1'b0;
    src_node = '0;
    rd_node  = '0;
    pq_full  = 1'b0;
    pl_req   = 1'b0;
    pl_node  = '0;
    pl_tag   = '0;
    clear_edges();
    test_reset();
    test_mid_init();
    test_isolated();
    test_chain();
    test_diamond();
    test_saturate();
    test_full();
    total++;
    if (viol != 0) begin
      bad++; $display("FAIL strobe_protocol: got %0d overlap/spacing violations want 0", viol);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
